// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with valid/ready request and result handshakes
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_kill,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out,
  output logic             o_busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [2:0]         r_op;
  logic               r_sa;
  logic               r_sb;
  logic [WIDTH-1:0]   r_mag_a;
  logic [WIDTH-1:0]   r_mag_b;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_out;

  logic               w_a_signed;
  logic               w_b_signed;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_div0;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_special_res;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_final;

  // Request decode: signedness, magnitudes and the cases that skip the iterative core
  always_comb begin
    w_a_signed = (i_op == 3'd0) || (i_op == 3'd1) || (i_op == 3'd2) || (i_op == 3'd4) || (i_op == 3'd6);
    w_b_signed = (i_op == 3'd0) || (i_op == 3'd1) || (i_op == 3'd4) || (i_op == 3'd6);
    w_sa       = w_a_signed & i_a[WIDTH-1];
    w_sb       = w_b_signed & i_b[WIDTH-1];
    w_mag_a    = w_sa ? -i_a : i_a;
    w_mag_b    = w_sb ? -i_b : i_b;
    w_div0     = i_op[2] && (i_b == '0);
    w_ovf      = ((i_op == 3'd4) || (i_op == 3'd6)) &&
                 (i_a == {1'b1, {(WIDTH-1){1'b0}}}) && (i_b == {WIDTH{1'b1}});
    w_special_res = '0;
    if (w_div0) begin
      w_special_res = i_op[1] ? i_a : {WIDTH{1'b1}};
    end else if (w_ovf) begin
      w_special_res = i_op[1] ? '0 : i_a;
    end
  end

  // Shift-add multiply step and restoring divide step share the product register
  always_comb begin
    w_mul_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_mag_a};
    w_mul_next  = r_prod[0] ? {w_mul_sum, r_prod[WIDTH-1:1]} : {1'b0, r_prod[2*WIDTH-1:1]};
    w_div_shift = r_prod[2*WIDTH-1:WIDTH-1];
    w_div_diff  = w_div_shift - {1'b0, r_mag_b};
    w_div_next  = w_div_diff[WIDTH] ? {w_div_shift[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b0}
                                    : {w_div_diff[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};
    w_prod_fix  = (r_sa ^ r_sb) ? -r_prod : r_prod;
    w_quo       = (r_sa ^ r_sb) ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0];
    w_rem       = r_sa ? -r_prod[2*WIDTH-1:WIDTH] : r_prod[2*WIDTH-1:WIDTH];
    if (r_op[2]) begin
      w_final = r_op[1] ? w_rem : w_quo;
    end else begin
      w_final = (r_op == 3'd0) ? w_prod_fix[WIDTH-1:0] : w_prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_mag_a <= '0;
      r_mag_b <= '0;
      r_prod  <= '0;
      r_out   <= '0;
    end else if (i_kill) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_op    <= i_op;
            r_sa    <= w_sa;
            r_sb    <= w_sb;
            r_mag_a <= w_mag_a;
            r_mag_b <= w_mag_b;
            r_cnt   <= '0;
            if (w_div0 || w_ovf) begin
              r_out   <= w_special_res;
              r_state <= S_DONE;
            end else begin
              r_prod  <= i_op[2] ? {{WIDTH{1'b0}}, w_mag_a} : {{WIDTH{1'b0}}, w_mag_b};
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (r_cnt == CNT_LAST) begin
            r_out   <= w_final;
            r_state <= S_DONE;
          end else begin
            r_prod <= r_op[2] ? w_div_next : w_mul_next;
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (i_out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready  = (r_state == S_IDLE);
  assign o_out_valid = (r_state == S_DONE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_out       = r_out;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        busy;

  int total;
  int bad;

  muldiv_unit #(.WIDTH(32)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_op        (op),
    .i_a         (a),
    .i_b         (b),
    .i_kill      (kill),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out       (out),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_req(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b);
    @(negedge clk);
    in_valid = 1'b1;
    op = t_op;
    a  = t_a;
    b  = t_b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 3'($urandom);
    a  = $urandom;
    b  = $urandom;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 100);
  endtask

  task automatic take_out;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                        output logic [31:0] res, output int lat);
    start_req(t_op, t_a, t_b);
    wait_out(lat);
    res = out;
    take_out();
  endtask

  task automatic test_reset;
    total += 4;
    if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (out !== 32'h0)      begin bad++; $display("FAIL reset_out got=%h want=00000000", out); end
  endtask

  task automatic test_mul;
    logic [31:0] res;
    int lat;
    run_op(3'd0, 32'd7, 32'hFFFFFFFD, res, lat);
    total += 2;
    if (res !== 32'hFFFFFFEB) begin bad++; $display("FAIL mul_7x-3 got=%h want=ffffffeb", res); end
    if (lat !== 33)           begin bad++; $display("FAIL mul_latency got=%0d want=33", lat); end
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat);
    total++;
    if (res !== 32'h00000000) begin bad++; $display("FAIL mulh got=%h want=00000000", res); end
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat);
    total++;
    if (res !== 32'hFFFFFFFE) begin bad++; $display("FAIL mulhu got=%h want=fffffffe", res); end
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat);
    total++;
    if (res !== 32'hFFFFFFFF) begin bad++; $display("FAIL mulhsu got=%h want=ffffffff", res); end
    run_op(3'd0, 32'h00012345, 32'h00010000, res, lat);
    total++;
    if (res !== 32'h23450000) begin bad++; $display("FAIL mul_low got=%h want=23450000", res); end
  endtask

  task automatic test_div;
    logic [31:0] res;
    int lat;
    run_op(3'd4, 32'hFFFFFFF9, 32'd2, res, lat);
    total += 2;
    if (res !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_-7/2 got=%h want=fffffffd", res); end
    if (lat !== 33)           begin bad++; $display("FAIL div_latency got=%0d want=33", lat); end
    run_op(3'd6, 32'hFFFFFFF9, 32'd2, res, lat);
    total++;
    if (res !== 32'hFFFFFFFF) begin bad++; $display("FAIL rem_-7%%2 got=%h want=ffffffff", res); end
    run_op(3'd5, 32'd100, 32'd7, res, lat);
    total++;
    if (res !== 32'd14)       begin bad++; $display("FAIL divu_100/7 got=%0d want=14", res); end
    run_op(3'd7, 32'd100, 32'd7, res, lat);
    total++;
    if (res !== 32'd2)        begin bad++; $display("FAIL remu_100%%7 got=%0d want=2", res); end
  endtask

  task automatic test_special;
    logic [31:0] res;
    int lat;
    run_op(3'd4, 32'd5, 32'd0, res, lat);
    total += 2;
    if (res !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_by_zero got=%h want=ffffffff", res); end
    if (lat !== 1)            begin bad++; $display("FAIL div_by_zero_latency got=%0d want=1", lat); end
    run_op(3'd6, 32'd5, 32'd0, res, lat);
    total += 2;
    if (res !== 32'd5)        begin bad++; $display("FAIL rem_by_zero got=%h want=00000005", res); end
    if (lat !== 1)            begin bad++; $display("FAIL rem_by_zero_latency got=%0d want=1", lat); end
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, res, lat);
    total += 2;
    if (res !== 32'h80000000) begin bad++; $display("FAIL div_overflow got=%h want=80000000", res); end
    if (lat !== 1)            begin bad++; $display("FAIL div_overflow_latency got=%0d want=1", lat); end
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, res, lat);
    total++;
    if (res !== 32'h0)        begin bad++; $display("FAIL rem_overflow got=%h want=00000000", res); end
  endtask

  task automatic test_backpressure;
    int lat;
    int unstable;
    start_req(3'd5, 32'd1000, 32'd10);
    wait_out(lat);
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out !== 32'd100 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) unstable++;
    end
    total++;
    if (unstable !== 0) begin bad++; $display("FAIL backpressure_hold got=%0d_bad_cycles want=0", unstable); end
    take_out();
    total += 2;
    if (in_ready !== 1'b1)  begin bad++; $display("FAIL handoff_in_ready got=%b want=1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL handoff_out_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_kill;
    logic [31:0] res;
    int lat;
    int seen;
    start_req(3'd0, 32'd123, 32'd456);
    repeat (10) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    total += 2;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL kill_in_ready got=%b want=1", in_ready); end
    if (busy !== 1'b0)     begin bad++; $display("FAIL kill_busy got=%b want=0", busy); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL kill_no_result got=%0d want=0", seen); end
    @(negedge clk);
    in_valid = 1'b1;
    kill = 1'b1;
    op = 3'd0;
    a = 32'd2;
    b = 32'd2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    kill = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL kill_drops_request got=%b want=0", busy); end
    run_op(3'd0, 32'd3, 32'd4, res, lat);
    total++;
    if (res !== 32'd12) begin bad++; $display("FAIL mul_after_kill got=%0d want=12", res); end
  endtask

  task automatic test_async_reset;
    logic [31:0] res;
    int lat;
    run_op(3'd3, 32'h00000010, 32'h10000000, res, lat);
    start_req(3'd0, 32'd99, 32'd99);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    total += 4;
    if (busy !== 1'b0)      begin bad++; $display("FAIL async_rst_busy got=%b want=0", busy); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL async_rst_out_valid got=%b want=0", out_valid); end
    if (out !== 32'h0)      begin bad++; $display("FAIL async_rst_out got=%h want=00000000", out); end
    if (in_ready !== 1'b1)  begin bad++; $display("FAIL async_rst_in_ready got=%b want=1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    run_op(3'd5, 32'd9, 32'd3, res, lat);
    total++;
    if (res !== 32'd3) begin bad++; $display("FAIL divu_after_rst got=%0d want=3", res); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    op = 3'd0;
    a = 32'd0;
    b = 32'd0;
    kill = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_kill();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit that sits beside the single-cycle ALU in the execute stage and takes the operations the combinational datapath does not handle. It takes a request (operation plus two operands) over a valid/ready handshake and computes the result over multiple cycles. It returns the result over a second valid/ready handshake. The pipeline stalls on `busy` and can abort an in-flight operation with `kill` on a flush.

## Interface
- `WIDTH`, 32 — operand/result width; cycle count of the iterative core equals `WIDTH`.
- `clk`  input  1  — single clock; all state updates on the rising edge.
- `rst`  input  1  — asynchronous, active-high reset.
- `in_valid`  input  1  — request present on `op`, `A`, `B`.
- `in_ready`  output  1  — unit can accept a request; high only in IDLE.
- `op`  input  3  — RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `A`  input  WIDTH  — rs1 operand (dividend / multiplicand).
- `B`  input  WIDTH  — rs2 operand (divisor / multiplier).
- `kill`  input  1  — synchronous abort; discard current operation.
- `out_valid`  output  1  — `Out` holds a finished result.
- `out_ready`  input  1  — consumer takes the result this cycle.
- `Out`  output  WIDTH  — result.
- `busy`  output  1  — high in CALC and DONE.

## Operation
- States: IDLE, CALC, DONE. Reset state IDLE.
- IDLE: `in_ready`=1. On `in_valid`, latch `op`, `A`, `B` and operand signs. Go to DONE if the request is a special case, else go to CALC with counter = 0.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
- Signed operands are converted to magnitudes. The core is unsigned, and the result is negated at the end when required.
- Multiply: radix-2 shift-add, 2·WIDTH-bit product register, one multiplier bit per cycle.
  - Product sign = sA ^ sB (signed operands only).
  - MUL returns product[WIDTH-1:0].
  - MULH, MULHSU and MULHU return product[2·WIDTH-1:WIDTH].
- Divide: restoring, one quotient bit per cycle.
  - Quotient sign = sA ^ sB.
  - Remainder sign = sA.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases resolve in IDLE with no CALC phase:
  - Divide by zero (B == 0): DIV/DIVU return all-ones; REM/REMU return A.
  - Signed overflow (DIV/REM with A = 0x80000000 and B = 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- CALC: counter increments every cycle. After WIDTH iterations, apply sign fix, register `Out` and go to DONE.
- DONE: `out_valid`=1 and `Out` held stable. On `out_ready`, return to IDLE. `out_valid` holds until accepted.
- `kill`: in any state, next state is IDLE, `out_valid` deasserts, and no result is produced.
  - `kill` has priority over `in_valid` and `out_ready` in the same cycle.
  - A request presented in IDLE together with `kill` is dropped.
- Reset values:
  - state IDLE, `in_ready`=1, `out_valid`=0, `busy`=0.
  - `Out`=0, counter = 0, internal registers = 0.
- Reset mid-operation: asynchronous return to IDLE, all outputs immediately at their reset values.

## Timing
- Request accepted on edge E0, when `in_valid` and `in_ready` are both high.
- Normal ops: CALC occupies WIDTH cycles. `out_valid` is first high in the cycle after edge E0+WIDTH+1, which is 33 edges for WIDTH = 32.
- Special cases: `out_valid` is high in the cycle after E0 (1-cycle latency).
- Result handoff: earliest new accept is one cycle after the `out_valid`&`out_ready` edge. There is no same-cycle back-to-back accept.
- `in_ready` and `out_valid` are purely state-decoded, with no combinational path from inputs.
- `busy` = (state != IDLE).
- Operand inputs may change freely after the accept edge.

## Test plan
- MUL 7 × (−3) (A=7, B=0xFFFFFFFD) -> `Out`=0xFFFFFFEB, `out_valid` rises 33 edges after accept.
- MULH/MULHU/MULHSU with A=B=0xFFFFFFFF -> MULH 0x00000000, MULHU 0xFFFFFFFE, MULHSU 0xFFFFFFFF.
- DIV −7 / 2 (A=0xFFFFFFF9, B=2) -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases:
  - DIV A=5, B=0 -> 0xFFFFFFFF.
  - REM A=5, B=0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - Each with `out_valid` one cycle after accept.
- Backpressure and kill:
  - Hold `out_ready`=0 for 10 cycles in DONE -> `Out` and `out_valid` stable, `in_ready`=0.
  - Assert `kill` at CALC cycle 10 -> IDLE next edge, no `out_valid`; a following MUL 3×4 returns 12.
- Assert `rst` asynchronously mid-CALC -> `busy`, `out_valid` and `Out` go to 0 immediately, `in_ready`=1; after release, DIVU 9/3 returns 3.
